// File: rtl/ntt_bram_stream_io_if.sv
// Stream and BRAM-port bundle for ntt_bram_stream_io.
// slave = the stream/BRAM controller; master = the surrounding environment.
interface ntt_bram_stream_io_if #(
    parameter int DW = 18,
    parameter int AW = 7
);
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          bram_wr_en;
    logic [AW-1:0] bram_wr_addr;
    logic [DW-1:0] bram_wr_din;
    logic [AW-1:0] bram_rd_addr;
    logic [DW-1:0] bram_rd_dout;

    modport slave (
        input  s_valid, s_data, m_ready, bram_rd_dout,
        output s_ready, m_valid, m_data,
        output bram_wr_en, bram_wr_addr, bram_wr_din, bram_rd_addr
    );

    modport master (
        output s_valid, s_data, m_ready, bram_rd_dout,
        input  s_ready, m_valid, m_data,
        input  bram_wr_en, bram_wr_addr, bram_wr_din, bram_rd_addr
    );
endinterface

// File: rtl/ntt_bram_stream_io.sv
// Load/unload streaming front end for the NTT coefficient BRAM.
// Define BITREV_LOAD_EN to write loaded words at bit-reversed addresses.
module ntt_bram_stream_io #(
    parameter int DW = 18,
    parameter int AW = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic                  unload_start,
    ntt_bram_stream_io_if.slave   io,
    output logic                  loaded,
    output logic                  unloaded,
    output logic                  busy
);
    localparam int        N    = 1 << AW;
    localparam logic [AW:0] LAST = (AW+1)'(N - 1);

    typedef enum logic [1:0] {IDLE, LOAD, FULL, UNLOAD} state_t;

    state_t        state_reg;
    logic [AW:0]   wcnt_reg;
    logic [AW:0]   rcnt_reg;
    logic [AW:0]   ocnt_reg;
    logic          wr_en_reg;
    logic [AW-1:0] wr_addr_reg;
    logic [DW-1:0] wr_din_reg;
    logic          loaded_reg;
    logic          rd_pend_reg;
    logic [DW-1:0] buf_reg [2];
    logic          wptr_reg;
    logic          rptr_reg;
    logic [1:0]    occ_reg;

    logic          accept;
    logic          pop;
    logic          issue;
    logic          last_pop;
    logic [1:0]    occ_after_pop;
    logic [AW-1:0] waddr;

`ifdef BITREV_LOAD_EN
    genvar gi;
    for (gi = 0; gi < AW; gi++) begin : g_bitrev
        assign waddr[gi] = wcnt_reg[AW-1-gi];
    end
`else
    assign waddr = wcnt_reg[AW-1:0];
`endif

    assign accept        = (state_reg == LOAD) && io.s_valid;
    assign pop           = (occ_reg != 2'd0) && io.m_ready;
    assign last_pop      = (state_reg == UNLOAD) && pop && (ocnt_reg == LAST);
    // Credit this cycle's pop so a free-flowing stream sustains one word per cycle.
    assign occ_after_pop = occ_reg - {1'b0, pop};
    assign issue         = (state_reg == UNLOAD) && !rcnt_reg[AW] &&
                           ((occ_after_pop + {1'b0, rd_pend_reg}) < 2'd2);

    assign io.s_ready      = (state_reg == LOAD);
    assign io.m_valid      = (occ_reg != 2'd0);
    assign io.m_data       = buf_reg[rptr_reg];
    assign io.bram_wr_en   = wr_en_reg;
    assign io.bram_wr_addr = wr_addr_reg;
    assign io.bram_wr_din  = wr_din_reg;
    assign io.bram_rd_addr = rcnt_reg[AW-1:0];
    assign loaded          = loaded_reg;
    assign unloaded        = last_pop;
    assign busy            = (state_reg == LOAD) || (state_reg == UNLOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            wcnt_reg    <= '0;
            rcnt_reg    <= '0;
            ocnt_reg    <= '0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_din_reg  <= '0;
            loaded_reg  <= 1'b0;
            rd_pend_reg <= 1'b0;
            wptr_reg    <= 1'b0;
            rptr_reg    <= 1'b0;
            occ_reg     <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_reg[i] <= '0;
            end
        end else begin
            // Write side: register the accepted word towards the BRAM port.
            wr_en_reg  <= accept;
            loaded_reg <= accept && (wcnt_reg == LAST);
            if (accept) begin
                wr_addr_reg <= waddr;
                wr_din_reg  <= io.s_data;
                wcnt_reg    <= wcnt_reg + 1'b1;
            end

            // Read side: the word addressed last cycle lands in the buffer now.
            rd_pend_reg <= issue;
            if (issue) begin
                rcnt_reg <= rcnt_reg + 1'b1;
            end
            if (rd_pend_reg) begin
                buf_reg[wptr_reg] <= io.bram_rd_dout;
                wptr_reg          <= ~wptr_reg;
            end
            if (pop) begin
                rptr_reg <= ~rptr_reg;
                ocnt_reg <= ocnt_reg + 1'b1;
            end
            occ_reg <= occ_reg + {1'b0, rd_pend_reg} - {1'b0, pop};

            case (state_reg)
                IDLE: begin
                    if (load_start) begin
                        state_reg <= LOAD;
                        wcnt_reg  <= '0;
                    end
                end
                LOAD: begin
                    if (accept && (wcnt_reg == LAST)) begin
                        state_reg <= FULL;
                    end
                end
                FULL: begin
                    if (unload_start) begin
                        state_reg <= UNLOAD;
                        rcnt_reg  <= '0;
                        ocnt_reg  <= '0;
                    end
                end
                UNLOAD: begin
                    if (last_pop) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ntt_bram_stream_io.sv
// Directed bench for ntt_bram_stream_io with a behavioural 128x18 BRAM.
// Expected write addresses follow BITREV_LOAD_EN when it is defined.
module tb_ntt_bram_stream_io;
    localparam int DW = 18;
    localparam int AW = 7;
    localparam int N  = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_start = 1'b0;
    logic unload_start = 1'b0;
    logic loaded, unloaded, busy;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] golden [N];
    int first_addr [4];
    int exp_first [4];

    ntt_bram_stream_io_if #(.DW(DW), .AW(AW)) io ();

    ntt_bram_stream_io #(.DW(DW), .AW(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_start   (load_start),
        .unload_start (unload_start),
        .io           (io),
        .loaded       (loaded),
        .unloaded     (unloaded),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] bram [N];
    always @(posedge clk) begin
        if (io.bram_wr_en) bram[io.bram_wr_addr] <= io.bram_wr_din;
        io.bram_rd_dout <= bram[io.bram_rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_addr(input int w);
`ifdef BITREV_LOAD_EN
        int r;
        r = 0;
        for (int b = 0; b < AW; b++) r = r | (((w >> b) & 1) << (AW - 1 - b));
        return r;
`else
        return w;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input string name, input int gap, input int base,
                              input int stop, input bit with_unload);
        int acc, wr, rdy, nloaded, cyc;
        bit prev_acc, done;
        acc = 0; wr = 0; rdy = 0; nloaded = 0; prev_acc = 1'b0; done = 1'b0;
        load_start = 1'b1;
        unload_start = with_unload;
        step();
        load_start = 1'b0;
        unload_start = 1'b0;
        check({name, "_busy"}, busy, 1);
        for (cyc = 0; cyc < 2000 && !done; cyc++) begin
            io.s_valid = ((cyc % gap) == 0) && (acc < stop);
            io.s_data  = DW'(base + acc);
            #1;
            check({name, "_wr_en"}, io.bram_wr_en, prev_acc);
            if (io.bram_wr_en) begin
                check({name, "_wr_addr"}, io.bram_wr_addr, exp_addr(wr));
                check({name, "_wr_din"}, io.bram_wr_din, base + wr);
                golden[exp_addr(wr)] = DW'(base + wr);
                if (wr < 4) first_addr[wr] = int'(io.bram_wr_addr);
                wr++;
            end
            check({name, "_loaded"}, loaded, io.bram_wr_en && (wr == N));
            if (loaded) nloaded++;
            if (io.s_ready) rdy++;
            prev_acc = io.s_ready && io.s_valid;
            if (prev_acc) acc++;
            if (wr == stop) done = 1'b1;
            if (!done) step();
        end
        io.s_valid = 1'b0;
        check({name, "_timeout"}, done, 1);
        check({name, "_writes"}, wr, stop);
        if (stop == N) begin
            check({name, "_loaded_count"}, nloaded, 1);
            check({name, "_ready_after"}, io.s_ready, 0);
            if (gap == 1) check({name, "_ready_cycles"}, rdy, N);
        end
        $display("load %s: writes=%0d ready_cycles=%0d loaded_pulses=%0d", name, wr, rdy, nloaded);
    endtask

    task automatic unload_frame(input string name, input int mode);
        int k, popped, issued, first_v, last_pop, nunl;
        logic [AW-1:0] prev_ra;
        logic [DW-1:0] prev_data;
        bit prev_stall, done, pop;
        popped = 0; issued = 0; first_v = -1; last_pop = -1; nunl = 0;
        prev_stall = 1'b0; done = 1'b0; prev_data = '0;
        unload_start = 1'b1;
        step();
        unload_start = 1'b0;
        prev_ra = io.bram_rd_addr;
        for (k = 0; k < 2000 && !done; k++) begin
            io.m_ready = (mode == 0) ? 1'b1 : (((k % 4) == 0) || ((k % 4) == 3));
            #1;
            if (io.bram_rd_addr != prev_ra) issued++;
            prev_ra = io.bram_rd_addr;
            check({name, "_outstanding"}, (issued - popped) <= 2, 1);
            if (prev_stall) begin
                check({name, "_hold_valid"}, io.m_valid, 1);
                check({name, "_hold_data"}, io.m_data, prev_data);
            end
            if (io.m_valid && first_v < 0) first_v = k;
            pop = io.m_valid && io.m_ready;
            check({name, "_unloaded"}, unloaded, pop && (popped == N - 1));
            if (pop) begin
                check({name, "_m_data"}, io.m_data, golden[popped]);
                if (unloaded) nunl++;
                popped++;
                last_pop = k;
                if (popped == N) done = 1'b1;
            end
            prev_stall = io.m_valid && !io.m_ready;
            prev_data  = io.m_data;
            step();
        end
        io.m_ready = 1'b0;
        check({name, "_timeout"}, done, 1);
        check({name, "_words"}, popped, N);
        check({name, "_unloaded_count"}, nunl, 1);
        check({name, "_busy_after"}, busy, 0);
        check({name, "_valid_after"}, io.m_valid, 0);
        if (mode == 0) begin
            check({name, "_first_latency"}, first_v, 2);
            check({name, "_last_pop_cycle"}, last_pop, N + 1);
        end
        $display("unload %s: words=%0d first_valid=%0d last_pop=%0d reads=%0d", name, popped, first_v, last_pop, issued);
    endtask

    initial begin
`ifdef BITREV_LOAD_EN
        exp_first = '{0, 64, 32, 96};
`else
        exp_first = '{0, 1, 2, 3};
`endif
        io.s_valid = 1'b0;
        io.s_data  = '0;
        io.m_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", io.s_ready, 0);
        check("rst_m_valid", io.m_valid, 0);
        check("rst_wr_en", io.bram_wr_en, 0);
        check("rst_loaded", loaded, 0);
        check("rst_unloaded", unloaded, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_addr", io.bram_wr_addr, 0);
        check("rst_wr_din", io.bram_wr_din, 0);
        check("rst_rd_addr", io.bram_rd_addr, 0);
        check("rst_m_data", io.m_data, 0);
        $display("reset: outputs sampled");
        rst_n = 1'b1;
        step();

`ifdef BITREV_LOAD_EN
        load_frame("contig", 1, 0, N, 1'b0);
`else
        load_frame("contig", 1, 1, N, 1'b0);
`endif
        for (int i = 0; i < 4; i++) check("first_addr", first_addr[i], exp_first[i]);

        load_start = 1'b1;
        step();
        load_start = 1'b0;
        step();
        check("ign_load_busy", busy, 0);
        check("ign_load_ready", io.s_ready, 0);
        $display("load_start in FULL: busy=%0d s_ready=%0d", busy, io.s_ready);

        unload_frame("fullrate", 0);

        unload_start = 1'b1;
        step();
        unload_start = 1'b0;
        step();
        check("ign_unload_busy", busy, 0);
        check("ign_unload_valid", io.m_valid, 0);
        $display("unload_start in IDLE: busy=%0d m_valid=%0d", busy, io.m_valid);

        load_frame("gap3_both_starts", 3, 1000, N, 1'b1);
        unload_frame("backpressure", 1);

        load_frame("abort", 1, 1, 50, 1'b0);
        rst_n = 1'b0;
        step();
        check("abort_busy", busy, 0);
        check("abort_wr_en", io.bram_wr_en, 0);
        check("abort_ready", io.s_ready, 0);
        check("abort_wr_addr", io.bram_wr_addr, 0);
        $display("reset mid-load: busy=%0d wr_en=%0d", busy, io.bram_wr_en);
        rst_n = 1'b1;
        step();
        load_frame("after_reset", 1, 7, N, 1'b0);
        unload_frame("after_reset", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ntt_bram_stream_io.md
Name: ntt_bram_stream_io

Overview:
- Streaming front/back end for the 128 x 18-bit dual-port coefficient BRAM used by the NTT datapath.
- Load phase: accepts a valid/ready stream of coefficients and writes them into the BRAM write port.
- Unload phase: sweeps the BRAM read port (1-cycle registered-address read latency) and presents the coefficients on a valid/ready output stream.
- A 2-entry output buffer absorbs downstream backpressure.

Parameters:
- DW, 18, coefficient / BRAM word width
- AW, 7, BRAM address width; N = 2**AW words per frame (128)

Ports:
- clk  input  1  system clock; all logic on posedge
- rst_n  input  1  asynchronous active-low reset
- load_start  input  1  single-cycle pulse; begins a load frame (honoured only in IDLE)
- unload_start  input  1  single-cycle pulse; begins an unload frame (honoured only in FULL)
- s_valid  input  1  input coefficient valid
- s_data  input  DW  input coefficient
- s_ready  output  1  input ready; asserted exactly when state==LOAD
- m_valid  output  1  output coefficient valid
- m_data  output  DW  output coefficient
- m_ready  input  1  downstream ready
- bram_wr_en  output  1  to BRAM wr_en
- bram_wr_addr  output  AW  to BRAM wr_addr
- bram_wr_din  output  DW  to BRAM wr_din
- bram_rd_addr  output  AW  to BRAM rd_addr
- bram_rd_dout  input  DW  from BRAM rd_dout; valid the cycle after bram_rd_addr is sampled
- loaded  output  1  1-cycle pulse when the N-th word is written
- unloaded  output  1  1-cycle pulse when the N-th word leaves m_data
- busy  output  1  high in LOAD and UNLOAD

Behaviour:
- Reset state (async, rst_n=0):
  - state=IDLE; all counters 0; output buffer empty.
  - s_ready, m_valid, bram_wr_en, loaded, unloaded, busy = 0.
  - bram_wr_addr, bram_wr_din, bram_rd_addr, m_data = 0.
  - BRAM contents are untouched.
- States:
  - IDLE: load_start -> LOAD, wcnt=0.
  - LOAD: on each s_valid&&s_ready, register bram_wr_en=1, bram_wr_addr=waddr(wcnt), bram_wr_din=s_data, then wcnt++. The write occurs one cycle after acceptance; bram_wr_en=0 on cycles with no acceptance. On the N-th acceptance, go to FULL at the same edge, so s_ready drops the next cycle. loaded pulses in the cycle the N-th write is presented on bram_wr_*.
  - FULL: s_ready=0. unload_start -> UNLOAD, rcnt=0, ocnt=0.
  - UNLOAD:
    - Read issue: issue a read (bram_rd_addr=rcnt, rcnt++) only when rcnt<N and buffer occupancy + reads in flight < 2.
    - Data return: bram_rd_dout is pushed into the buffer the cycle after issue.
    - Output: m_valid = buffer non-empty; m_data = buffer head. A pop on m_valid&&m_ready increments ocnt.
    - Exit: the pop making ocnt==N pulses unloaded and returns to IDLE.
- Ordering: output is strictly in address order 0..N-1. No words are dropped or duplicated under any m_ready pattern.
- Throughput: 1 word/cycle in both phases when upstream/downstream never stall.
- First-word latency: m_valid rises 2 cycles after unload_start is sampled (address issue, then buffer push).
- Boundary conditions:
  - Counters are AW+1 bits wide so that N is representable; addresses use the low AW bits.
  - load_start outside IDLE and unload_start outside FULL are ignored.
  - Simultaneous load_start and unload_start in IDLE: load wins.
  - A full buffer with m_ready=0 holds m_valid/m_data stable and stalls read issue.
  - Reset mid-frame aborts the frame; the partially written BRAM is left as-is; the next frame starts at address 0.
  - The phases are exclusive, so there is never a same-address read/write collision.

Optional Feature:
- Macro BITREV_LOAD_EN.
- Defined: waddr(wcnt) = bit-reverse of wcnt[AW-1:0] (e.g. word 1 -> address 64, word 3 -> address 96), which feeds a decimation-in-time NTT with natural-order input. Unload remains natural order.
- Undefined: waddr(wcnt) = wcnt[AW-1:0].

Test Plan:
- Reset then load 128 words s_data=i+1 with s_valid always 1 -> s_ready high for exactly 128 cycles; bram_wr_addr 0..127 with bram_wr_din 1..128; loaded pulses once with bram_wr_addr=127.
- After the load, unload with m_ready=1 -> m_valid 2 cycles after unload_start; m_data 1..128 on consecutive cycles; unloaded pulses on the word with value 128; busy falls; state returns to IDLE.
- Unload with m_ready toggling 1,0,0,1 repeatedly -> all 128 words delivered in order with no duplicates; m_data stable whenever m_valid=1 and m_ready=0; never more than 2 outstanding reads.
- Load with s_valid gaps (valid every third cycle) -> bram_wr_en high only on write cycles; addresses contiguous; 128 writes total.
- Assert rst_n=0 after 50 loaded words, then run a full load -> first write after reset goes to address 0; loaded pulses after exactly 128 further writes.
- With BITREV_LOAD_EN defined, load s_data=i -> words 0,1,2,3 written to addresses 0,64,32,96; a subsequent unload emits the bit-reversed permutation.
